// File: rtl/nibble_add_sequencer.sv
// Sequences a shared external 4-bit adder over NIBBLES slices, LSB nibble first,
// chaining the carry through a register and reporting carry-out and signed overflow.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   add_x,
  output logic [3:0]   add_y,
  output logic         add_cin,
  input  logic [3:0]   add_z,
  input  logic         add_cout
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic            busy_reg, done_reg;
  logic            cout_reg, ovf_reg;
  logic [3:0]      a_nib, b_nib;
  logic            ovf_next;

  // Select the operand nibbles addressed by idx; idx never exceeds LAST_IDX.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IW'(i)) begin
        a_nib = a_reg[i*4 +: 4];
        b_nib = b_reg[i*4 +: 4];
      end
    end
  end

  // Only meaningful on the MSB nibble; earlier RUN cycles are overwritten.
  assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (add_z[3] != a_reg[W-1]);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    add_x      = 4'h0;
    add_y      = 4'h0;
    add_cin    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          idx_next   = '0;
        end
      end
      S_RUN: begin
        add_x   = a_nib;
        add_y   = b_nib;
        add_cin = carry_reg;
        if (idx_reg == LAST_IDX) begin
          state_next = S_DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      busy_reg  <= (state_next == S_RUN);
      done_reg  <= (state_next == S_DONE);
      if (state_reg == S_IDLE && start) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
      end
      if (state_reg == S_RUN) begin
        carry_reg <= add_cout;
        cout_reg  <= add_cout;
        ovf_reg   <= ovf_next;
      end
    end
  end

  // One result register per nibble, written only in the RUN cycle that owns it.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum
      logic [3:0] sum_nib_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_nib_reg <= 4'h0;
        end else if (state_reg == S_RUN && idx_reg == IW'(gi)) begin
          sum_nib_reg <= add_z;
        end
      end
      assign sum[gi*4 +: 4] = sum_nib_reg;
    end
  endgenerate

  assign busy = busy_reg;
  assign done = done_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
